// File: rtl/dm_bytelane_mem.sv
// Byte-addressed data memory with byte/half/word lanes, load extension and a post-reset init sweep.
// Optional per-word even parity is built when DM_PARITY_EN is defined.
module dm_bytelane_mem #(
  parameter int DEPTH        = 256,
  parameter int IDX_W        = $clog2(DEPTH),
  parameter bit INIT_PATTERN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] read_adr,
  input  logic [31:0] write_adr,
  input  logic [31:0] write_data,
  input  logic        memwrite,
  input  logic        memread,
  input  logic [1:0]  rd_size,
  input  logic        rd_unsigned,
  input  logic [1:0]  wr_size,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        misalign,
  output logic        parity_err
);

  typedef enum logic {INIT, RUN} state_t;

  state_t           state;
  logic [IDX_W-1:0] cnt;
  logic             ready_q;

  logic [31:0] mem [DEPTH];

  logic [IDX_W-1:0] ridx, widx;
  logic [31:0]      rword, wold, wlane, merged, init_word, ext;
  logic [3:0]       be;
  logic             rd_mis, wr_mis, store_en, rd_ok;

  // Upper address bits are intentionally dropped so accesses wrap modulo the memory size.
  logic unused_adr_bits;
  assign unused_adr_bits = &{1'b0, read_adr[31:IDX_W+2], write_adr[31:IDX_W+2]};

  function automatic logic is_mis(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return lo[0];
      default: return lo != 2'b00;
    endcase
  endfunction

  assign ridx      = read_adr[IDX_W+1:2];
  assign widx      = write_adr[IDX_W+1:2];
  assign rword     = mem[ridx];
  assign wold      = mem[widx];
  assign rd_mis    = is_mis(rd_size, read_adr[1:0]);
  assign wr_mis    = is_mis(wr_size, write_adr[1:0]);
  assign init_word = INIT_PATTERN ? 32'(cnt) : 32'd0;
  assign store_en  = ~reset & ready_q & memwrite & ~wr_mis;
  assign rd_ok     = ~reset & ready_q & memread & ~rd_mis;

  assign ready    = ready_q & ~reset;
  assign misalign = ~reset & ((memread & rd_mis) | (memwrite & wr_mis));

  // Store lanes: replicate the right-aligned data across the word, then pick lanes by byte enable.
  always_comb begin
    be    = 4'b1111;
    wlane = write_data;
    case (wr_size)
      2'b00: begin
        be    = 4'b0001 << write_adr[1:0];
        wlane = {4{write_data[7:0]}};
      end
      2'b01: begin
        be    = write_adr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{write_data[15:0]}};
      end
      default: ;
    endcase
    for (int i = 0; i < 4; i++)
      merged[8*i +: 8] = be[i] ? wlane[8*i +: 8] : wold[8*i +: 8];
  end

  always_comb begin
    logic [31:0] shifted;
    logic [15:0] half;
    shifted = rword >> {read_adr[1:0], 3'b000};
    half    = read_adr[1] ? rword[31:16] : rword[15:0];
    case (rd_size)
      2'b00:   ext = rd_unsigned ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   ext = rd_unsigned ? {16'd0, half} : {{16{half[15]}}, half};
      default: ext = rword;
    endcase
    read_data = rd_ok ? ext : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= INIT;
      cnt     <= '0;
      ready_q <= 1'b0;
    end else if (state == INIT) begin
      cnt <= cnt + 1'b1;
      if (&cnt) begin
        state   <= RUN;
        ready_q <= 1'b1;
      end
    end
  end

  // NOTE: the storage array has no reset branch; contents are defined only by the INIT sweep,
  // which keeps it mappable to RAM and avoids a DEPTH-wide reset fan-out.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == INIT)
        mem[cnt] <= init_word;
      else if (store_en)
        mem[widx] <= merged;
    end
  end

`ifdef DM_PARITY_EN
  logic par_mem [DEPTH];
  logic force_bad_par;

  // Test hook only: driven low here and overridden hierarchically to corrupt one write.
  assign force_bad_par = 1'b0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == INIT)
        par_mem[cnt] <= (^init_word) ^ force_bad_par;
      else if (store_en)
        par_mem[widx] <= (^merged) ^ force_bad_par;
    end
  end

  assign parity_err = memread & ready & ~misalign & (par_mem[ridx] != ^rword);
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_dm_bytelane_mem.sv
// Self-checking bench for dm_bytelane_mem: directed scenarios plus randomized traffic
// compared against a byte-array reference model.
module tb_dm_bytelane_mem;

  localparam int DEPTH  = 256;
  localparam int NBYTES = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] read_adr, write_adr, write_data;
  logic        memwrite, memread, rd_unsigned;
  logic [1:0]  rd_size, wr_size;
  logic [31:0] read_data;
  logic        ready, misalign, parity_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] mbytes [NBYTES];
  bit         model_ready = 1'b0;

  dm_bytelane_mem #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .read_adr   (read_adr),
    .write_adr  (write_adr),
    .write_data (write_data),
    .memwrite   (memwrite),
    .memread    (memread),
    .rd_size    (rd_size),
    .rd_unsigned(rd_unsigned),
    .wr_size    (wr_size),
    .read_data  (read_data),
    .ready      (ready),
    .misalign   (misalign),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int nbytes_of(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit mis_of(input logic [1:0] size, input logic [31:0] adr);
    int n = nbytes_of(size);
    return (adr % n) != 0;
  endfunction

  function automatic logic [31:0] model_load(input bit en, input logic [31:0] adr,
                                             input logic [1:0] size, input bit uns);
    int          n = nbytes_of(size);
    int          a;
    logic [31:0] v = 0;
    if (!en || !model_ready || mis_of(size, adr)) return 32'd0;
    a = int'(adr % NBYTES);
    for (int k = 0; k < n; k++) v = v | (32'(mbytes[a + k]) << (8 * k));
    if (!uns && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
    if (!uns && n == 2 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  function automatic void model_store(input logic [31:0] adr, input logic [31:0] data,
                                      input logic [1:0] size);
    int n = nbytes_of(size);
    int a;
    if (!model_ready || mis_of(size, adr)) return;
    a = int'(adr % NBYTES);
    for (int k = 0; k < n; k++) mbytes[a + k] = data[8*k +: 8];
  endfunction

  function automatic void model_fill();
    for (int i = 0; i < DEPTH; i++)
      for (int k = 0; k < 4; k++) mbytes[4*i + k] = 8'((i >> (8 * k)) & 255);
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic store(input logic [31:0] adr, input logic [31:0] data, input logic [1:0] size);
    write_adr  = adr;
    write_data = data;
    wr_size    = size;
    memwrite   = 1'b1;
    tick();
    model_store(adr, data, size);
    memwrite = 1'b0;
  endtask

  task automatic load_check(input string tag, input logic [31:0] adr, input logic [1:0] size,
                            input bit uns, input logic [31:0] exp);
    read_adr    = adr;
    rd_size     = size;
    rd_unsigned = uns;
    memread     = 1'b1;
    #1;
    check(tag, read_data, exp);
    memread = 1'b0;
  endtask

  // Release reset and walk through the INIT sweep, reading word 4*i each cycle.
  task automatic init_sweep(input string tag);
    reset   = 1'b0;
    memread = 1'b1;
    rd_size = 2'b10;
    for (int e = 1; e <= DEPTH; e++) begin
      read_adr = 32'(4 * (e - 1));
      tick();
      if (e < DEPTH) begin
        check({tag, "_ready_low"}, {31'd0, ready}, 32'd0);
        check({tag, "_rdata_zero"}, read_data, 32'd0);
      end else begin
        model_fill();
        model_ready = 1'b1;
        check({tag, "_ready_high"}, {31'd0, ready}, 32'd1);
        check({tag, "_last_word"}, read_data, model_load(1'b1, read_adr, 2'b10, 1'b0));
      end
    end
    memread = 1'b0;
  endtask

  initial begin
    reset = 1'b1; memread = 1'b1; memwrite = 1'b1;
    read_adr = 32'h1; write_adr = 32'h2; write_data = 32'h0;
    rd_size = 2'b10; wr_size = 2'b10; rd_unsigned = 1'b0;

    // Reset hold: everything reads zero even with misaligned accesses presented.
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_ready", {31'd0, ready}, 32'd0);
      check("rst_rdata", read_data, 32'd0);
      check("rst_misalign", {31'd0, misalign}, 32'd0);
      check("rst_parity", {31'd0, parity_err}, 32'd0);
    end
    memwrite = 1'b0;
    init_sweep("init");

    load_check("lw_3fc", 32'h3FC, 2'b10, 1'b0, 32'h0000_00FF);
    load_check("lw_040", 32'h040, 2'b10, 1'b0, 32'h0000_0010);

    store(32'h10, 32'h8081_7F02, 2'b10);
    load_check("lb_10",  32'h10, 2'b00, 1'b0, 32'h0000_0002);
    load_check("lb_13",  32'h13, 2'b00, 1'b0, 32'hFFFF_FF80);
    load_check("lbu_13", 32'h13, 2'b00, 1'b1, 32'h0000_0080);
    load_check("lh_12",  32'h12, 2'b01, 1'b0, 32'hFFFF_8081);
    load_check("lhu_12", 32'h12, 2'b01, 1'b1, 32'h0000_8081);
    load_check("lh_10",  32'h10, 2'b01, 1'b0, 32'h0000_7F02);

    store(32'h11, 32'h0000_00AB, 2'b00);
    store(32'h12, 32'h0000_1234, 2'b01);
    load_check("lw_sub", 32'h10, 2'b10, 1'b0, 32'h1234_AB02);

    // Misaligned store and load, separately and together.
    write_adr = 32'h22; write_data = 32'hDEAD_BEEF; wr_size = 2'b10; memwrite = 1'b1;
    #1 check("mis_sw", {31'd0, misalign}, 32'd1);
    read_adr = 32'h21; rd_size = 2'b01; rd_unsigned = 1'b0; memread = 1'b1;
    #1 check("mis_both", {31'd0, misalign}, 32'd1);
    check("mis_lh_data", read_data, 32'd0);
    tick();
    memwrite = 1'b0;
    #1 check("mis_lh_only", {31'd0, misalign}, 32'd1);
    memread = 1'b0;
    load_check("mis_no_write", 32'h20, 2'b10, 1'b0, 32'h0000_0008);

    // Reset while running restarts INIT and restores the fill pattern.
    store(32'h8, 32'hFFFF_FFFF, 2'b10);
    load_check("lw_8_ff", 32'h8, 2'b10, 1'b0, 32'hFFFF_FFFF);
    reset = 1'b1;
    model_ready = 1'b0;
    tick();
    check("rst2_ready", {31'd0, ready}, 32'd0);
    init_sweep("reinit");
    load_check("lw_8_init", 32'h8, 2'b10, 1'b0, 32'h0000_0002);
    load_check("lw_408_wrap", 32'h408, 2'b10, 1'b0, 32'h0000_0002);

    // Same-address read and write: no forwarding.
    read_adr = 32'h30; rd_size = 2'b10; memread = 1'b1;
    write_adr = 32'h30; write_data = 32'h55; wr_size = 2'b10; memwrite = 1'b1;
    #1 check("rw_before", read_data, 32'h0000_000C);
    check("rw_par_before", {31'd0, parity_err}, 32'd0);
    tick();
    model_store(32'h30, 32'h55, 2'b10);
    memwrite = 1'b0;
    #1 check("rw_after", read_data, 32'h0000_0055);
    check("rw_par_after", {31'd0, parity_err}, 32'd0);
    memread = 1'b0;

`ifdef DM_PARITY_EN
    force dut.force_bad_par = 1'b1;
    store(32'h34, 32'h77, 2'b10);
    release dut.force_bad_par;
    read_adr = 32'h34; rd_size = 2'b10; memread = 1'b1;
    #1 check("par_forced", {31'd0, parity_err}, 32'd1);
    read_adr = 32'h38;
    #1 check("par_clean", {31'd0, parity_err}, 32'd0);
    memread = 1'b0;
    store(32'h34, 32'h77, 2'b10);
`endif

    // Randomized traffic against the byte model, concentrated on a small window for reuse.
    for (int it = 0; it < 400; it++) begin
      logic [31:0] ra, wa;
      bit          exp_mis;
      ra = $urandom;
      wa = $urandom;
      if ($urandom_range(0, 3) != 0) ra[9:6] = 4'd0;
      if ($urandom_range(0, 3) != 0) wa[9:6] = 4'd0;
      if ($urandom_range(0, 7) == 0) wa = ra;
      read_adr    = ra;
      write_adr   = wa;
      write_data  = $urandom;
      rd_size     = 2'($urandom_range(0, 3));
      wr_size     = 2'($urandom_range(0, 3));
      rd_unsigned = 1'($urandom_range(0, 1));
      memread     = 1'($urandom_range(0, 3) != 0);
      memwrite    = 1'($urandom_range(0, 1));
      #1;
      exp_mis = (memread && mis_of(rd_size, ra)) || (memwrite && mis_of(wr_size, wa));
      check("rnd_rdata", read_data, model_load(memread, ra, rd_size, rd_unsigned));
      check("rnd_misalign", {31'd0, misalign}, {31'd0, exp_mis});
      check("rnd_parity", {31'd0, parity_err}, 32'd0);
      @(posedge clk);
      if (memwrite) model_store(wa, write_data, wr_size);
      @(negedge clk);
    end
    memread  = 1'b0;
    memwrite = 1'b0;

    // Sweep every word once to confirm final contents.
    for (int i = 0; i < DEPTH; i++)
      load_check("final_word", 32'(4 * i), 2'b10, 1'b0, model_load(1'b1, 32'(4 * i), 2'b10, 1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dm_bytelane_mem.md
Name: dm_bytelane_mem

Overview:
- Parametrised, byte-addressed data memory for the single-cycle MIPS datapath.
- Successor to the fixed 256-word, word-only data memory.
- Adds configurable depth, byte/halfword/word accesses with load sign/zero extension, misalignment detection, and a post-reset initialisation sequencer with a ready flag.
- Sits between the ALU address output and the writeback mux. Read is combinational; writes commit on the rising clock edge.

Parameters:
- DEPTH, 256, number of 32-bit words; power of two, at least 4.
- IDX_W, $clog2(DEPTH), word-index width; derived, never overridden.
- INIT_PATTERN, 1, fill value written to each word after reset: 1 = word index i; 0 = zero.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- read_adr  in  32  byte address for loads.
- write_adr  in  32  byte address for stores.
- write_data  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- memwrite  in  1  store strobe, sampled at the rising edge.
- memread  in  1  load enable.
- rd_size  in  2  load size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- rd_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend loads.
- wr_size  in  2  store size, same encoding as rd_size.
- read_data  out  32  extended load result.
- ready  out  1  memory initialised and accepting accesses.
- misalign  out  1  combinational; current read or write access is misaligned.
- parity_err  out  1  parity mismatch on the current read (optional feature only).

Behaviour:
- Word index = adr[IDX_W+1:2]; upper address bits are ignored, so addresses wrap modulo 4*DEPTH bytes. Little-endian byte lanes: adr[1:0]=0 selects bits [7:0].
- FSM states: INIT, RUN.
  - reset=1 at an edge: state <= INIT, init counter <= 0, ready <= 0.
  - INIT: each edge with reset=0 writes mem[cnt] <= (INIT_PATTERN ? cnt : 0) and increments cnt. When cnt == DEPTH-1 the write occurs and state <= RUN, ready <= 1.
  - ready is 1 exactly DEPTH edges after the first edge with reset low.
  - Reset asserted mid-INIT or in RUN restarts INIT from 0. Memory contents are not cleared by reset itself, only by the INIT sweep.
- Outputs while reset is high: ready=0, read_data=0, misalign=0, parity_err=0.
- Read, combinational:
  - read_data = 0 when memread=0, ready=0, or the read is misaligned.
  - Otherwise the selected lane(s) are extended per rd_unsigned; word reads ignore rd_unsigned.
- Write: at a rising edge with memwrite=1, ready=1 and an aligned address, update only the addressed lanes. Byte store writes one lane; half store writes lanes {adr[1],0} and {adr[1],1}.
  - memwrite during INIT is ignored; the INIT write has priority.
- Alignment: half is misaligned when adr[0]=1; word is misaligned when adr[1:0]!=0.
  - misalign = (memread & read misaligned) | (memwrite & write misaligned).
  - A misaligned store is suppressed, with no partial write.
- Same-address read and write in one cycle: read_data shows the old contents until the edge and the new contents after it. There is no forwarding.

Optional Feature:
- Macro DM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit, computed on every write (including INIT writes) over the full 32-bit word after the lane merge.
  - parity_err = memread & ready & !misalign & (stored parity != ^word).
  - A hierarchical-only test hook, force_bad_par, inverts the parity bit of the next committed write.
- Undefined: no parity storage is built and parity_err is tied to 0.

Test Plan:
- Init sequence: hold reset for 5 edges, release, read word addr 4*i every cycle.
  - -> ready=0 and read_data=0 for the first 255 edges; ready=1 after edge 256.
  - -> lw 0x3FC returns 0x000000FF; lw 0x040 returns 0x00000010.
- Word store then sub-word loads: sw 0x80817F02 @0x10.
  - -> lb 0x10 = 0x00000002; lb 0x13 = 0xFFFFFF80; lbu 0x13 = 0x00000080.
  - -> lh 0x12 = 0xFFFF8081; lhu 0x12 = 0x00008081; lh 0x10 = 0x00007F02.
- Sub-word stores: from the state above, sb 0xAB @0x11 then sh 0x1234 @0x12.
  - -> lw 0x10 = 0x1234AB02.
- Misalignment: sw 0xDEADBEEF @0x22 and lh @0x21.
  - -> misalign=1 for both; word 0x20 still reads 0x00000008; lh returns 0.
- Reset mid-operation and wrap: assert reset for 1 edge when ready=1 after storing 0xFFFFFFFF @0x8.
  - -> ready=0 for 256 edges, then lw 0x8 = 0x00000002.
  - -> lw 0x408 (wraps to word 2) = 0x00000002.
- Simultaneous read/write @0x30 with memread=1, sw 0x55 applied for one edge.
  - -> read_data = 0x0000000C before the edge, 0x00000055 after it.
  - -> with DM_PARITY_EN defined, parity_err stays 0 throughout; after a force_bad_par write, parity_err=1 on the next read of that word.
